// File: rtl/cnn_defs_pkg.sv
// Shared constants, derived sizes and FSM encoding for the float16 CNN stream loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cnn_defs_pkg;

  localparam int DATA_WIDTH              = 16;
  localparam int PARA_X                  = 3;
  localparam int PARA_Y                  = 3;
  localparam int PARA_KERNEL             = 2;
  localparam int KERNEL_SIZE_MAX         = 5;
  localparam int KERNEL_SIZE_WIDTH       = 6;
  localparam int WRITE_ADDR_WIDTH        = 3;
  localparam int WEIGHT_WRITE_ADDR_WIDTH = 5;

  // Derived block geometry
  localparam int FM_WORDS     = PARA_X * PARA_Y;
  localparam int KSLICE_WORDS = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int W_WORDS      = KSLICE_WORDS * PARA_KERNEL;
  localparam int FM_BITS      = FM_WORDS * DATA_WIDTH;
  localparam int W_BITS       = W_WORDS * DATA_WIDTH;

  // Counter / index widths inside the packer
  localparam int POS_WIDTH     = $clog2(W_WORDS);
  localparam int BIT_POS_WIDTH = $clog2(W_BITS);
  localparam int KCNT_WIDTH    = $clog2(PARA_KERNEL + 1);

  localparam logic [DATA_WIDTH-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_FM = 2'd1,
    ST_LOAD_W  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs serial float16 words into a wide block register at runtime-configured positions.
// Latency: pack_nxt/last are combinational on the accepted word; the register updates next edge.
// Backpressure: none; only counts words flagged by in_vld (the caller owns the handshake).
module word_packer
  import cnn_defs_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_vld,
  input  logic [DATA_WIDTH-1:0]     in_dat,
  input  logic [POS_WIDTH-1:0]      slice_len,
  input  logic [KCNT_WIDTH-1:0]     kern_num,
  input  logic [POS_WIDTH-1:0]      slice_stride,
  output logic [W_BITS-1:0]         pack_nxt,
  output logic                      last
);

  localparam logic [POS_WIDTH-1:0]  POS_ONE  = 1;
  localparam logic [KCNT_WIDTH-1:0] KCNT_ONE = 1;

  logic [W_BITS-1:0]        pack_q;
  logic [POS_WIDTH-1:0]     word_cnt;
  logic [KCNT_WIDTH-1:0]    kern_cnt;
  logic [POS_WIDTH-1:0]     word_pos;
  logic [BIT_POS_WIDTH-1:0] bit_pos;
  logic                     slice_end;
  logic                     kern_end;

  assign slice_end = (word_cnt == slice_len - POS_ONE);
  assign kern_end  = (kern_cnt == kern_num - KCNT_ONE);
  assign last      = in_vld && slice_end && kern_end;

  // First word of a slice lands in its highest used word position.
  assign word_pos = POS_WIDTH'(kern_cnt) * slice_stride + (slice_len - POS_ONE - word_cnt);
  assign bit_pos  = BIT_POS_WIDTH'(word_pos) * BIT_POS_WIDTH'(DATA_WIDTH);

  // Block value including the word being accepted this cycle
  always_comb begin
    pack_nxt = pack_q;
    if (in_vld) begin
      pack_nxt[bit_pos +: DATA_WIDTH] = in_dat;
    end
  end

  // Accumulate words; wipe the register once a block completes so unused words read zero
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      pack_q   <= {W_WORDS{FP16_ZERO}};
      word_cnt <= '0;
      kern_cnt <= '0;
    end else if (in_vld) begin
      pack_q <= last ? {W_WORDS{FP16_ZERO}} : pack_nxt;
      if (slice_end) begin
        word_cnt <= '0;
        kern_cnt <= kern_end ? '0 : kern_cnt + KCNT_ONE;
      end else begin
        word_cnt <= word_cnt + POS_ONE;
      end
    end
  end

endmodule

// File: rtl/cnn_stream_loader.sv
// Streams float16 words into FM blocks then weight blocks and writes them to the layer RAM ports.
// Latency: write strobe/data/address one cycle after a block's last word; done flags rise with the final strobe.
// Backpressure: s_ready drops for the single write cycle after each block and outside the load states.
module cnn_stream_loader
  import cnn_defs_pkg::*;
(
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [KERNEL_SIZE_WIDTH-1:0]                  kernel_size,
  input  logic [WRITE_ADDR_WIDTH:0]                     fm_block_num,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH:0]              weight_block_num,
  input  logic [DATA_WIDTH-1:0]                         s_data,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  output logic [FM_BITS-1:0]                            init_fm_data,
  output logic [WRITE_ADDR_WIDTH-1:0]                   write_fm_data_addr,
  output logic                                          fm_wr_en,
  output logic [W_BITS-1:0]                             weight_data,
  output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr,
  output logic                                          weight_wr_en,
  output logic                                          init_fm_data_done,
  output logic                                          weight_data_done,
  output logic                                          busy,
  output logic                                          cfg_err
);

  localparam logic [KERNEL_SIZE_WIDTH-1:0]       KS_MAX   = KERNEL_SIZE_MAX;
  localparam logic [POS_WIDTH-1:0]               FM_LEN   = FM_WORDS;
  localparam logic [POS_WIDTH-1:0]               KSTRIDE  = KSLICE_WORDS;
  localparam logic [KCNT_WIDTH-1:0]              KCNT_ONE = 1;
  localparam logic [KCNT_WIDTH-1:0]              KCNT_PK  = PARA_KERNEL;
  localparam logic [WRITE_ADDR_WIDTH:0]          FM_ONE   = 1;
  localparam logic [WEIGHT_WRITE_ADDR_WIDTH:0]   W_ONE    = 1;

  state_t                            state;
  logic [KERNEL_SIZE_WIDTH-1:0]      k_q;
  logic [WRITE_ADDR_WIDTH:0]         fm_num_q;
  logic [WEIGHT_WRITE_ADDR_WIDTH:0]  w_num_q;
  logic [WRITE_ADDR_WIDTH:0]         fm_blk_cnt;
  logic [WEIGHT_WRITE_ADDR_WIDTH:0]  w_blk_cnt;

  logic                  start_ok;
  logic                  k_legal;
  logic                  accept;
  logic                  fm_phase;
  logic [POS_WIDTH-1:0]  ksq;
  logic [POS_WIDTH-1:0]  slice_len;
  logic [KCNT_WIDTH-1:0] kern_num;
  logic [W_BITS-1:0]     pack_nxt;
  logic                  pk_last;
  logic                  fm_last_blk;
  logic                  w_last_blk;

  assign start_ok    = start && (state == ST_IDLE || state == ST_DONE);
  assign k_legal     = (kernel_size != '0) && (kernel_size <= KS_MAX);
  assign accept      = s_valid && s_ready;
  assign fm_phase    = (state == ST_LOAD_FM);
  assign ksq         = POS_WIDTH'(k_q * k_q);
  assign slice_len   = fm_phase ? FM_LEN : ksq;
  assign kern_num    = fm_phase ? KCNT_ONE : KCNT_PK;
  assign fm_last_blk = (fm_blk_cnt == fm_num_q - FM_ONE);
  assign w_last_blk  = (w_blk_cnt == w_num_q - W_ONE);

  word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_ok),
    .in_vld       (accept),
    .in_dat       (s_data),
    .slice_len    (slice_len),
    .kern_num     (kern_num),
    .slice_stride (KSTRIDE),
    .pack_nxt     (pack_nxt),
    .last         (pk_last)
  );

  // Load sequencer with registered handshake, strobes, RAM data/address and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                  <= ST_IDLE;
      k_q                    <= '0;
      fm_num_q               <= '0;
      w_num_q                <= '0;
      fm_blk_cnt             <= '0;
      w_blk_cnt              <= '0;
      s_ready                <= 1'b0;
      init_fm_data           <= '0;
      write_fm_data_addr     <= '0;
      fm_wr_en               <= 1'b0;
      weight_data            <= '0;
      write_weight_data_addr <= '0;
      weight_wr_en           <= 1'b0;
      init_fm_data_done      <= 1'b0;
      weight_data_done       <= 1'b0;
      busy                   <= 1'b0;
      cfg_err                <= 1'b0;
    end else begin
      fm_wr_en     <= 1'b0;
      weight_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            k_q               <= kernel_size;
            fm_num_q          <= fm_block_num;
            w_num_q           <= weight_block_num;
            fm_blk_cnt        <= '0;
            w_blk_cnt         <= '0;
            init_fm_data_done <= 1'b0;
            weight_data_done  <= 1'b0;
            cfg_err           <= 1'b0;
            if (!k_legal) begin
              state   <= ST_DONE;
              cfg_err <= 1'b1;
            end else if (fm_block_num != '0) begin
              state   <= ST_LOAD_FM;
              busy    <= 1'b1;
              s_ready <= 1'b1;
            end else if (weight_block_num != '0) begin
              state   <= ST_LOAD_W;
              busy    <= 1'b1;
              s_ready <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_LOAD_FM: begin
          if (!s_ready) begin
            s_ready <= 1'b1;  // write cycle over, reopen the stream
          end else if (pk_last) begin
            fm_wr_en           <= 1'b1;
            init_fm_data       <= pack_nxt[FM_BITS-1:0];
            write_fm_data_addr <= fm_blk_cnt[WRITE_ADDR_WIDTH-1:0];
            fm_blk_cnt         <= fm_blk_cnt + FM_ONE;
            s_ready            <= 1'b0;
            if (fm_last_blk) begin
              init_fm_data_done <= 1'b1;
              if (w_num_q != '0) begin
                state <= ST_LOAD_W;
              end else begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end
            end
          end
        end
        ST_LOAD_W: begin
          if (!s_ready) begin
            s_ready <= 1'b1;
          end else if (pk_last) begin
            weight_wr_en           <= 1'b1;
            weight_data            <= pack_nxt;
            write_weight_data_addr <= {PARA_KERNEL{w_blk_cnt[WEIGHT_WRITE_ADDR_WIDTH-1:0]}};
            w_blk_cnt              <= w_blk_cnt + W_ONE;
            s_ready                <= 1'b0;
            if (w_last_blk) begin
              weight_data_done <= 1'b1;
              state            <= ST_DONE;
              busy             <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_stream_loader.sv
// Directed bench for cnn_stream_loader: FM/weight packing, addressing, handshake timing and control corner cases.
// Latency: checks strobes one cycle after the last word and done flags with the final strobe.
// Backpressure: drives s_valid with and without bubbles; inputs change on the falling edge.
module tb_cnn_stream_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   kernel_size = '0;
  logic [3:0]   fm_block_num = '0;
  logic [5:0]   weight_block_num = '0;
  logic [15:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [143:0] init_fm_data;
  logic [2:0]   write_fm_data_addr;
  logic         fm_wr_en;
  logic [799:0] weight_data;
  logic [9:0]   write_weight_data_addr;
  logic         weight_wr_en;
  logic         init_fm_data_done;
  logic         weight_data_done;
  logic         busy;
  logic         cfg_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  bit first_pending = 1'b0;

  logic [143:0] fm_cap [0:7];
  logic [799:0] w_cap  [0:31];
  logic [2:0]   fm_addr_q [$];
  logic [9:0]   w_addr_q  [$];
  logic         fm_done_at, w_done_at, w_busy_at;
  int           sready_cnt = 0;

  cnn_stream_loader dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .kernel_size            (kernel_size),
    .fm_block_num           (fm_block_num),
    .weight_block_num       (weight_block_num),
    .s_data                 (s_data),
    .s_valid                (s_valid),
    .s_ready                (s_ready),
    .init_fm_data           (init_fm_data),
    .write_fm_data_addr     (write_fm_data_addr),
    .fm_wr_en               (fm_wr_en),
    .weight_data            (weight_data),
    .write_weight_data_addr (write_weight_data_addr),
    .weight_wr_en           (weight_wr_en),
    .init_fm_data_done      (init_fm_data_done),
    .weight_data_done       (weight_data_done),
    .busy                   (busy),
    .cfg_err                (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Capture RAM writes and status seen alongside each strobe
  always @(negedge clk) begin
    if (fm_wr_en) begin
      fm_cap[write_fm_data_addr] = init_fm_data;
      fm_addr_q.push_back(write_fm_data_addr);
      fm_done_at = init_fm_data_done;
    end
    if (weight_wr_en) begin
      w_cap[write_weight_data_addr[4:0]] = weight_data;
      w_addr_q.push_back(write_weight_data_addr);
      w_done_at = weight_data_done;
      w_busy_at = busy;
    end
    if (s_ready) sready_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] fm_word(input int b, input int i);
    return 16'h1000 + 16'(b * 16 + i);
  endfunction

  function automatic logic [15:0] w_word(input int b, input int j, input int i);
    return 16'h2000 + 16'(b * 256 + j * 32 + i);
  endfunction

  // First received word sits at the top of the FM block
  function automatic logic [143:0] exp_fm(input int b);
    logic [143:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[(8 - i) * 16 +: 16] = fm_word(b, i);
    return r;
  endfunction

  // Each kernel slice is 25 words wide; only the low K*K words are filled
  function automatic logic [799:0] exp_w(input int b, input int k);
    logic [799:0] r;
    r = '0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < k * k; i++) r[j * 400 + (k * k - 1 - i) * 16 +: 16] = w_word(b, j, i);
    return r;
  endfunction

  task automatic clear_log();
    fm_addr_q.delete();
    w_addr_q.delete();
    fm_done_at = 1'b0;
    w_done_at  = 1'b0;
    w_busy_at  = 1'b1;
    for (int i = 0; i < 8; i++) fm_cap[i] = '0;
    for (int i = 0; i < 32; i++) w_cap[i] = '0;
  endtask

  task automatic do_start(input int k, input int f, input int w);
    kernel_size      = 6'(k);
    fm_block_num     = 4'(f);
    weight_block_num = 6'(w);
    start            = 1'b1;
    @(negedge clk);
    start            = 1'b0;
  endtask

  // Present one word and hold it until the loader takes it; entered and left on a falling edge
  task automatic send_word(input logic [15:0] d);
    int t;
    t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, t);
    end else begin
      if (first_pending) begin
        t0 = cyc;
        first_pending = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic bubble(input bit en);
    if (en && $urandom_range(0, 2) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic load_blocks(input int f0, input int fnum, input int wnum, input int k, input bit bub);
    for (int b = 0; b < fnum; b++)
      for (int i = 0; i < 9; i++) begin
        bubble(bub);
        send_word(fm_word(f0 + b, i));
      end
    for (int b = 0; b < wnum; b++)
      for (int j = 0; j < 2; j++)
        for (int i = 0; i < k * k; i++) begin
          bubble(bub);
          send_word(w_word(b, j, i));
        end
    s_valid = 1'b0;
  endtask

  task automatic wait_flag(input bit weight, output int tc);
    int t;
    t = 0;
    while (((weight ? weight_data_done : init_fm_data_done) !== 1'b1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    tc = cyc;
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_done: flag(weight=%0b) never rose within %0d cycles", weight, t);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [999:0] agg;
    agg = '0;
    agg[0] = s_ready; agg[1] = fm_wr_en; agg[2] = weight_wr_en;
    agg[3] = init_fm_data_done; agg[4] = weight_data_done; agg[5] = busy; agg[6] = cfg_err;
    agg[9:7] = write_fm_data_addr; agg[19:10] = write_weight_data_addr;
    agg[163:20] = init_fm_data; agg[963:164] = weight_data;
    checks++;
    if (agg !== '0) begin
      errors++;
      $display("FAIL %s: outputs ctl=%b addr=%h/%h not all zero", name, agg[6:0], write_fm_data_addr, write_weight_data_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic_fm();
    logic [15:0]  w [0:8];
    logic [143:0] exp;
    int tc;
    w = '{16'h4200, 16'h4000, 16'h0000, 16'h4000, 16'h3c00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp = {16'h4200, 16'h4000, 16'h0000, 16'h4000, 16'h3c00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    clear_log();
    do_start(3, 1, 0);
    for (int i = 0; i < 9; i++) send_word(w[i]);
    s_valid = 1'b0;
    wait_flag(1'b0, tc);
    @(negedge clk); #1;
    checks++; if (fm_addr_q.size() !== 1) begin errors++; $display("FAIL basic_fm_count: got %0d writes, required 1", fm_addr_q.size()); end
    checks++; if (fm_cap[0] !== exp) begin errors++; $display("FAIL basic_fm_data: got %h required %h", fm_cap[0], exp); end
    checks++; if (fm_done_at !== 1'b1) begin errors++; $display("FAIL basic_fm_done_with_strobe: got %b required 1", fm_done_at); end
    checks++; if (weight_data_done !== 1'b0 || w_addr_q.size() !== 0) begin errors++; $display("FAIL basic_fm_no_weights: wdone=%b wwrites=%0d required 0/0", weight_data_done, w_addr_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_fm_busy: got %b required 0", busy); end
  endtask

  task automatic check_full_contents(input string name, input int fnum, input int wnum, input int k);
    checks++;
    if (fm_addr_q.size() !== fnum || w_addr_q.size() !== wnum) begin
      errors++;
      $display("FAIL %s_counts: fm=%0d w=%0d required %0d/%0d", name, fm_addr_q.size(), w_addr_q.size(), fnum, wnum);
    end
    for (int b = 0; b < fnum && b < fm_addr_q.size(); b++) begin
      checks++;
      if (fm_addr_q[b] !== 3'(b) || fm_cap[b] !== exp_fm(b)) begin
        errors++;
        $display("FAIL %s_fm%0d: addr=%0d data=%h required addr=%0d data=%h", name, b, fm_addr_q[b], fm_cap[b], b, exp_fm(b));
      end
    end
    for (int b = 0; b < wnum && b < w_addr_q.size(); b++) begin
      checks++;
      if (w_addr_q[b] !== {5'(b), 5'(b)} || w_cap[b] !== exp_w(b, k)) begin
        errors++;
        $display("FAIL %s_w%0d: addr=%h data=%h required addr=%h data=%h", name, b, w_addr_q[b], w_cap[b], {5'(b), 5'(b)}, exp_w(b, k));
      end
    end
  endtask

  task automatic test_full_load();
    int t1;
    clear_log();
    do_start(3, 4, 2);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL start_to_ready: s_ready=%b required 1", s_ready); end
    first_pending = 1'b1;
    load_blocks(0, 4, 2, 3, 1'b0);
    wait_flag(1'b1, t1);
    checks++; if (t1 - t0 + 1 !== 78) begin errors++; $display("FAIL full_load_cycles: got %0d required 78", t1 - t0 + 1); end
    @(negedge clk); #1;
    check_full_contents("full", 4, 2, 3);
    checks++; if (w_done_at !== 1'b1 || w_busy_at !== 1'b0) begin errors++; $display("FAIL full_done_timing: done=%b busy=%b at last strobe, required 1/0", w_done_at, w_busy_at); end
    checks++; if (init_fm_data_done !== 1'b1) begin errors++; $display("FAIL full_fm_done_hold: got %b required 1", init_fm_data_done); end
  endtask

  task automatic test_backpressure();
    int t1;
    clear_log();
    do_start(3, 4, 2);
    for (int i = 0; i < 5; i++) send_word(fm_word(0, i));
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (fm_addr_q.size() !== 0 || s_ready !== 1'b1) begin errors++; $display("FAIL partial_block: writes=%0d s_ready=%b required 0/1", fm_addr_q.size(), s_ready); end
    for (int i = 5; i < 9; i++) begin bubble(1'b1); send_word(fm_word(0, i)); end
    load_blocks(1, 3, 2, 3, 1'b1);
    wait_flag(1'b1, t1);
    @(negedge clk); #1;
    check_full_contents("bp", 4, 2, 3);
  endtask

  task automatic test_illegal_cfg();
    int tc;
    clear_log();
    sready_cnt = 0;
    do_start(0, 1, 1);
    repeat (5) @(negedge clk);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || init_fm_data_done !== 1'b0 || weight_data_done !== 1'b0) begin errors++; $display("FAIL illegal_k0: err=%b busy=%b done=%b%b required 1,0,00", cfg_err, busy, init_fm_data_done, weight_data_done); end
    do_start(6, 1, 1);
    repeat (5) @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_k6: err=%b required 1", cfg_err); end
    checks++; if (sready_cnt !== 0 || fm_addr_q.size() !== 0 || w_addr_q.size() !== 0) begin errors++; $display("FAIL illegal_quiet: ready_cycles=%0d writes=%0d/%0d required 0", sready_cnt, fm_addr_q.size(), w_addr_q.size()); end
    do_start(3, 1, 0);
    checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL legal_clears_err: err=%b busy=%b required 0/1", cfg_err, busy); end
    load_blocks(0, 1, 0, 3, 1'b0);
    wait_flag(1'b0, tc);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_block();
    int tc;
    clear_log();
    do_start(3, 4, 0);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 9; i++) send_word(fm_word(b, i));
    for (int i = 0; i < 5; i++) send_word(fm_word(2, i));
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_outputs");
    checks++; if (fm_addr_q.size() !== 2) begin errors++; $display("FAIL reset_mid_no_strobe: writes=%0d required 2", fm_addr_q.size()); end
    rst = 1'b1;
    @(negedge clk);
    clear_log();
    do_start(3, 1, 0);
    load_blocks(5, 1, 0, 3, 1'b0);
    wait_flag(1'b0, tc);
    @(negedge clk); #1;
    checks++; if (fm_addr_q.size() !== 1 || fm_cap[0] !== exp_fm(5)) begin errors++; $display("FAIL restart_load: writes=%0d data=%h required 1 data=%h", fm_addr_q.size(), fm_cap[0], exp_fm(5)); end
  endtask

  task automatic test_wrap_ignore();
    int tc;
    clear_log();
    do_start(2, 8, 1);
    load_blocks(0, 8, 0, 2, 1'b0);
    for (int i = 0; i < 3; i++) send_word(w_word(0, 0, i));
    s_valid = 1'b0;
    do_start(0, 1, 0);
    kernel_size = 6'd2;
    checks++; if (busy !== 1'b1 || cfg_err !== 1'b0 || init_fm_data_done !== 1'b1) begin errors++; $display("FAIL start_while_busy: busy=%b err=%b fmdone=%b required 1,0,1", busy, cfg_err, init_fm_data_done); end
    send_word(w_word(0, 0, 3));
    for (int i = 0; i < 4; i++) send_word(w_word(0, 1, i));
    s_valid = 1'b0;
    wait_flag(1'b1, tc);
    repeat (4) @(negedge clk); #1;
    check_full_contents("wrap", 8, 1, 2);
    checks++; if (init_fm_data_done !== 1'b1 || weight_data_done !== 1'b1 || cfg_err !== 1'b0) begin errors++; $display("FAIL wrap_final_flags: fm=%b w=%b err=%b required 1,1,0", init_fm_data_done, weight_data_done, cfg_err); end
  endtask

  initial begin
    clear_log();
    @(negedge clk);
    test_reset();
    test_basic_fm();
    test_full_load();
    test_backpressure();
    test_illegal_cfg();
    test_reset_mid_block();
    test_wrap_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
